control_sequencer: RTL and testbench
====================================

# control_sequencer

Hardwired Mini SRC control unit for the existing single-bus datapath. It steps through a fixed T-state sequence: fetch in T0–T2, then an opcode-specific execute sequence. On each clock it drives every datapath control input the benches currently drive by hand. It sits beside `datapath`, reads back only the IR and `CON_out`, and replaces per-instruction testbench sequencing.

## Interface
- `MEM_WAIT`, default 0: extra cycles each memory step (fetch read, `ld` read, `st` write) is held.
- `clk`  in  1  rising-edge clock shared with datapath.
- `clr`  in  1  synchronous, active-high reset.
- `IR_Data`  in  32  instruction register contents; opcode is `IR_Data[31:27]`.
- `CON_out`  in  1  branch condition flip-flop output.
- `PC_in IR_in Y_in Z_in HI_in LO_in MAR_in MDR_in OutPort_in IncPC`  out  1 each  register load enables.
- `PC_out Zhigh_out Zlow_out HI_out LO_out MDR_out InPort_out C_out`  out  1 each  bus drivers.
- `Read Write`  out  1 each  RAM strobes.
- `Gra Grb Grc Rin Rout BAout CON_in`  out  1 each  select/encode and CON controls.
- `Link_in`  out  1  R15 load enable for `jal`.
- `alu_instruction_bits`  out  5  ALU operation code.
- `run`  out  1  high unless halted.

## Operation
- One state per clock. Outputs are a combinational function of state, `IR_Data`, `CON_out` and the wait counter. Anything not listed for a step is 0.
- Fetch:
  - T0: `PC_out MAR_in IncPC Z_in`.
  - T1: `Read MDR_in` for MEM_WAIT+1 cycles, with `Zlow_out PC_in` in the first cycle only.
  - T2: `MDR_out IR_in`.
- Execute begins at T3 from the latched opcode:
  - R-type ALU (add, sub, and, or, ror, rol, shr, shra, shl): T3 `Grb Rout Y_in`; T4 `Grc Rout Z_in`, alu=opcode; T5 `Zlow_out Gra Rin`.
  - neg, not: T3 `Grb Rout Z_in`, alu=opcode; T4 `Zlow_out Gra Rin`.
  - addi/andi/ori: as R-type, but T4 uses `C_out`; alu = 00011/00101/00110.
  - mul, div: T3 `Gra Rout Y_in`; T4 `Grb Rout Z_in`, alu=opcode; T5 `Zlow_out LO_in`; T6 `Zhigh_out HI_in`.
  - ld, ldi, st address phase: T3 `Grb BAout Y_in`; T4 `C_out Z_in`, alu=00011; T5 `Zlow_out MAR_in` (ldi: `Zlow_out Gra Rin`, done).
  - ld: T6 `Read MDR_in` (MEM_WAIT+1 cycles); T7 `MDR_out Gra Rin`.
  - st: T6 `Gra Rout MDR_in`; T7 `Write` (MEM_WAIT+1 cycles).
  - branch (brzr/brnz/brpl/brmi): T3 `Gra Rout CON_in`; T4 `PC_out Y_in`; T5 `C_out Z_in`, alu=00011; T6 `Zlow_out`, plus `PC_in` equal to `CON_out`.
  - jr: T3 `Gra Rout PC_in`.
  - jal: T3 `PC_out Link_in`; T4 `Gra Rout PC_in`.
  - mfhi/mflo: T3 `HI_out`/`LO_out` with `Gra Rin`.
  - in: T3 `InPort_out Gra Rin`.
  - out: T3 `Gra Rout OutPort_in`.
  - nop and undefined opcodes: no execute step.
  - halt: enter HALT.
- The last step of every sequence transitions to T0.
- HALT: all outputs 0 and `run`=0. Leaves only on `clr`.
- Wait counter: `$clog2(MEM_WAIT+1)` bits (min 1). Loads 0 on entry to a memory step, increments each cycle, and the step exits when it equals MEM_WAIT.

## Timing
- `clr` sampled at posedge: next state T0, counter 0, `run`=1. Outputs are forced 0 in any cycle where `clr` is high. `clr` mid-instruction abandons it; no partial register writes occur after the reset edge.
- Datapath registers capture at the posedge ending each step.
- `IR_Data` is decoded from T3 onward.
- `CON_out` is used in T6, three edges after `CON_in`.
- Cycle counts at MEM_WAIT=0: R-type 6, neg/not 5, mul/div 7, ldi 6, ld/st 8, branch 7, jr/mf/in/out 4, jal 5, nop 3.
- Each MEM_WAIT adds 1 cycle per memory step.

## Configuration
- `CU_MULDIV_EN` defined: mul/div sequences as above.
- `CU_MULDIV_EN` undefined: mul/div opcodes decode as nop (3 cycles, HI/LO untouched), and the T6 HI step is omitted from the state machine.

## Structure
- Shared package `minisrc_pkg`: opcode constants (ld=00000 … halt=11011), ALU code constants, state enum (T0–T7, HALT), instruction-class enum.
- Sub-module `cu_decoder`: combinational opcode → instruction class plus ALU code. The state register, wait counter and output logic live in `control_sequencer`.

## Test plan
- `clr` high 2 cycles, then low: all outputs 0 during reset; the first cycle after has `PC_out MAR_in IncPC Z_in`=1 and `run`=1.
- IR=0x1A920000 (add R5,R2,R4), R2=5, R4=7: R5=12 after 6 cycles; T4 `alu_instruction_bits`=00011.
- IR=0x9B000019 (brzr R6,25), PC=1:
  - R6=3: PC stays 1, with `PC_in`=0 in T6.
  - R6=0: PC=26 after T6.
- `ld` R1,0x54(R0) with mem[0x54]=0x97 and MEM_WAIT=2: R1=0x97; instruction completes in 12 cycles; `Read` high 3 cycles in each read step.
- IR=0xD8000000 (halt): `run`=0 from T3 onward, outputs stay 0 for 20 cycles, and `clr` restarts at T0. `clr` asserted during T5 of an add leaves R5 unchanged.
- mul R3,R4 (6×7) with `CU_MULDIV_EN`: LO=42, HI=0 in 7 cycles. Without it: LO/HI unchanged, 3 cycles.

Source files
------------

// File: rtl/minisrc_pkg.sv
// Shared Mini SRC definitions: opcodes, ALU codes, sequencer states, instruction classes
// and the packed control word driven onto the datapath.
package minisrc_pkg;

    localparam logic [4:0] OpLd   = 5'b00000;
    localparam logic [4:0] OpLdi  = 5'b00001;
    localparam logic [4:0] OpSt   = 5'b00010;
    localparam logic [4:0] OpAdd  = 5'b00011;
    localparam logic [4:0] OpSub  = 5'b00100;
    localparam logic [4:0] OpAnd  = 5'b00101;
    localparam logic [4:0] OpOr   = 5'b00110;
    localparam logic [4:0] OpRor  = 5'b00111;
    localparam logic [4:0] OpRol  = 5'b01000;
    localparam logic [4:0] OpShr  = 5'b01001;
    localparam logic [4:0] OpShra = 5'b01010;
    localparam logic [4:0] OpShl  = 5'b01011;
    localparam logic [4:0] OpAddi = 5'b01100;
    localparam logic [4:0] OpAndi = 5'b01101;
    localparam logic [4:0] OpOri  = 5'b01110;
    localparam logic [4:0] OpDiv  = 5'b01111;
    localparam logic [4:0] OpMul  = 5'b10000;
    localparam logic [4:0] OpNeg  = 5'b10001;
    localparam logic [4:0] OpNot  = 5'b10010;
    localparam logic [4:0] OpBr   = 5'b10011;
    localparam logic [4:0] OpJr   = 5'b10100;
    localparam logic [4:0] OpJal  = 5'b10101;
    localparam logic [4:0] OpIn   = 5'b10110;
    localparam logic [4:0] OpOut  = 5'b10111;
    localparam logic [4:0] OpMfhi = 5'b11000;
    localparam logic [4:0] OpMflo = 5'b11001;
    localparam logic [4:0] OpNop  = 5'b11010;
    localparam logic [4:0] OpHalt = 5'b11011;

    localparam logic [4:0] AluAdd = 5'b00011;
    localparam logic [4:0] AluAnd = 5'b00101;
    localparam logic [4:0] AluOr  = 5'b00110;

    typedef enum logic [3:0] {
        StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
    } state_t;

    typedef enum logic [3:0] {
        ClsAlu, ClsAluImm, ClsUnary, ClsMulDiv, ClsLd, ClsLdi, ClsSt, ClsBr,
        ClsJr, ClsJal, ClsMfhi, ClsMflo, ClsIn, ClsOut, ClsNop, ClsHalt
    } cls_t;

    typedef struct packed {
        logic pc_in, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, outport_in, inc_pc;
        logic pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out, inport_out, c_out;
        logic read, write, gra, grb, grc, rin, rout, ba_out, con_in, link_in;
        logic [4:0] alu;
        logic run;
    } ctrl_t;

    function automatic ctrl_t fetch_t0();
        ctrl_t c;
        c        = '0;
        c.run    = 1'b1;
        c.pc_out = 1'b1;
        c.mar_in = 1'b1;
        c.inc_pc = 1'b1;
        c.z_in   = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired control unit (master) and the single-bus datapath.
interface control_sequencer_if;
    logic [31:0] IR_Data;
    logic        CON_out;
    logic PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC;
    logic PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out;
    logic Read, Write;
    logic Gra, Grb, Grc, Rin, Rout, BAout, CON_in;
    logic Link_in;
    logic [4:0] alu_instruction_bits;
    logic run;

    modport master (
        input  IR_Data, CON_out,
        output PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
        output PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
        output Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, CON_in, Link_in,
        output alu_instruction_bits, run
    );

    modport slave (
        output IR_Data, CON_out,
        input  PC_in, IR_in, Y_in, Z_in, HI_in, LO_in, MAR_in, MDR_in, OutPort_in, IncPC,
        input  PC_out, Zhigh_out, Zlow_out, HI_out, LO_out, MDR_out, InPort_out, C_out,
        input  Read, Write, Gra, Grb, Grc, Rin, Rout, BAout, CON_in, Link_in,
        input  alu_instruction_bits, run
    );
endinterface

// File: rtl/cu_decoder.sv
// Combinational opcode decode to instruction class and ALU code.
// mul/div decode as nop unless CU_MULDIV_EN is defined.
module cu_decoder
    import minisrc_pkg::*;
(
    input  logic [4:0] opcode,
    output cls_t       cls,
    output logic [4:0] alu
);
    always_comb begin
        cls = ClsNop;
        alu = opcode;
        case (opcode)
            OpAdd, OpSub, OpAnd, OpOr, OpRor, OpRol, OpShr, OpShra, OpShl: cls = ClsAlu;
            OpAddi: begin cls = ClsAluImm; alu = AluAdd; end
            OpAndi: begin cls = ClsAluImm; alu = AluAnd; end
            OpOri:  begin cls = ClsAluImm; alu = AluOr;  end
            OpNeg, OpNot: cls = ClsUnary;
`ifdef CU_MULDIV_EN
            OpMul, OpDiv: cls = ClsMulDiv;
`else
            OpMul, OpDiv: cls = ClsNop;
`endif
            OpLd:   begin cls = ClsLd;  alu = AluAdd; end
            OpLdi:  begin cls = ClsLdi; alu = AluAdd; end
            OpSt:   begin cls = ClsSt;  alu = AluAdd; end
            OpBr:   begin cls = ClsBr;  alu = AluAdd; end
            OpJr:   cls = ClsJr;
            OpJal:  cls = ClsJal;
            OpMfhi: cls = ClsMfhi;
            OpMflo: cls = ClsMflo;
            OpIn:   cls = ClsIn;
            OpOut:  cls = ClsOut;
            OpHalt: cls = ClsHalt;
            default: cls = ClsNop;
        endcase
    end
endmodule

// File: rtl/control_sequencer.sv
// Hardwired Mini SRC control unit: T-state sequencer driving every datapath control.
// Optional CU_MULDIV_EN enables the mul/div sequences (LO at T5, HI at T6).
module control_sequencer
    import minisrc_pkg::*;
#(
    parameter int unsigned MEM_WAIT = 0
) (
    input  logic                 clk,
    input  logic                 clr,
    control_sequencer_if.master  bus
);
    localparam int unsigned CntW = (MEM_WAIT > 0) ? $clog2(MEM_WAIT + 1) : 1;

    cls_t            cls;
    logic [4:0]      dec_alu;
    state_t          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            cnt_done;
    ctrl_t           ctrl;

    cu_decoder u_dec (
        .opcode (bus.IR_Data[31:27]),
        .cls    (cls),
        .alu    (dec_alu)
    );

    assign cnt_done = (cnt_q == CntW'(MEM_WAIT));

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= StT0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        ctrl     = '0;
        ctrl.run = 1'b1;
        state_d  = state_q;
        cnt_d    = '0;
        unique case (state_q)
            StT0: begin ctrl = fetch_t0(); state_d = StT1; end
            StT1: begin
                ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
                ctrl.zlow_out = (cnt_q == '0); ctrl.pc_in = (cnt_q == '0);
                if (cnt_done) state_d = StT2;
                else cnt_d = cnt_q + CntW'(1);
            end
            StT2: begin ctrl.mdr_out = 1'b1; ctrl.ir_in = 1'b1; state_d = StT3; end
            StT3: begin
                state_d = StT4;
                case (cls)
                    ClsAlu, ClsAluImm: begin ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1; end
                    ClsUnary: begin
                        ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = dec_alu;
                    end
`ifdef CU_MULDIV_EN
                    ClsMulDiv: begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.y_in = 1'b1; end
`endif
                    ClsLd, ClsLdi, ClsSt: begin
                        ctrl.grb = 1'b1; ctrl.ba_out = 1'b1; ctrl.y_in = 1'b1;
                    end
                    ClsBr:  begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.con_in = 1'b1; end
                    ClsJal: begin ctrl.pc_out = 1'b1; ctrl.link_in = 1'b1; end
                    ClsJr: begin
                        ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pc_in = 1'b1; state_d = StT0;
                    end
                    ClsMfhi: begin
                        ctrl.hi_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; state_d = StT0;
                    end
                    ClsMflo: begin
                        ctrl.lo_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; state_d = StT0;
                    end
                    ClsIn: begin
                        ctrl.inport_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; state_d = StT0;
                    end
                    ClsOut: begin
                        ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.outport_in = 1'b1; state_d = StT0;
                    end
                    ClsHalt: begin ctrl.run = 1'b0; state_d = StHalt; end
                    // No execute step: this cycle already acts as T0 of the next fetch.
                    default: begin ctrl = fetch_t0(); state_d = StT1; end
                endcase
            end
            StT4: begin
                state_d = StT5;
                case (cls)
                    ClsAlu: begin
                        ctrl.grc = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = dec_alu;
                    end
                    ClsAluImm, ClsLd, ClsLdi, ClsSt: begin
                        ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = dec_alu;
                    end
                    ClsUnary: begin
                        ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; state_d = StT0;
                    end
`ifdef CU_MULDIV_EN
                    ClsMulDiv: begin
                        ctrl.grb = 1'b1; ctrl.rout = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = dec_alu;
                    end
`endif
                    ClsBr: begin ctrl.pc_out = 1'b1; ctrl.y_in = 1'b1; end
                    ClsJal: begin
                        ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.pc_in = 1'b1; state_d = StT0;
                    end
                    default: state_d = StT0;
                endcase
            end
            StT5: begin
                state_d = StT0;
                case (cls)
                    ClsAlu, ClsAluImm, ClsLdi: begin
                        ctrl.zlow_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1;
                    end
`ifdef CU_MULDIV_EN
                    ClsMulDiv: begin ctrl.zlow_out = 1'b1; ctrl.lo_in = 1'b1; state_d = StT6; end
`endif
                    ClsLd, ClsSt: begin ctrl.zlow_out = 1'b1; ctrl.mar_in = 1'b1; state_d = StT6; end
                    ClsBr: begin
                        ctrl.c_out = 1'b1; ctrl.z_in = 1'b1; ctrl.alu = dec_alu; state_d = StT6;
                    end
                    default: state_d = StT0;
                endcase
            end
            StT6: begin
                state_d = StT0;
                case (cls)
`ifdef CU_MULDIV_EN
                    ClsMulDiv: begin ctrl.zhigh_out = 1'b1; ctrl.hi_in = 1'b1; end
`endif
                    ClsLd: begin
                        ctrl.read = 1'b1; ctrl.mdr_in = 1'b1;
                        if (cnt_done) state_d = StT7;
                        else begin state_d = StT6; cnt_d = cnt_q + CntW'(1); end
                    end
                    ClsSt: begin ctrl.gra = 1'b1; ctrl.rout = 1'b1; ctrl.mdr_in = 1'b1; state_d = StT7; end
                    ClsBr: begin ctrl.zlow_out = 1'b1; ctrl.pc_in = bus.CON_out; end
                    default: state_d = StT0;
                endcase
            end
            StT7: begin
                state_d = StT0;
                case (cls)
                    ClsLd: begin ctrl.mdr_out = 1'b1; ctrl.gra = 1'b1; ctrl.rin = 1'b1; end
                    ClsSt: begin
                        ctrl.write = 1'b1;
                        if (!cnt_done) begin state_d = StT7; cnt_d = cnt_q + CntW'(1); end
                    end
                    default: state_d = StT0;
                endcase
            end
            StHalt: begin ctrl.run = 1'b0; state_d = StHalt; end
            default: state_d = StT0;
        endcase
        if (clr) ctrl = '0;
    end

    assign bus.PC_in                = ctrl.pc_in;
    assign bus.IR_in                = ctrl.ir_in;
    assign bus.Y_in                 = ctrl.y_in;
    assign bus.Z_in                 = ctrl.z_in;
    assign bus.HI_in                = ctrl.hi_in;
    assign bus.LO_in                = ctrl.lo_in;
    assign bus.MAR_in               = ctrl.mar_in;
    assign bus.MDR_in               = ctrl.mdr_in;
    assign bus.OutPort_in           = ctrl.outport_in;
    assign bus.IncPC                = ctrl.inc_pc;
    assign bus.PC_out               = ctrl.pc_out;
    assign bus.Zhigh_out            = ctrl.zhigh_out;
    assign bus.Zlow_out             = ctrl.zlow_out;
    assign bus.HI_out               = ctrl.hi_out;
    assign bus.LO_out               = ctrl.lo_out;
    assign bus.MDR_out              = ctrl.mdr_out;
    assign bus.InPort_out           = ctrl.inport_out;
    assign bus.C_out                = ctrl.c_out;
    assign bus.Read                 = ctrl.read;
    assign bus.Write                = ctrl.write;
    assign bus.Gra                  = ctrl.gra;
    assign bus.Grb                  = ctrl.grb;
    assign bus.Grc                  = ctrl.grc;
    assign bus.Rin                  = ctrl.rin;
    assign bus.Rout                 = ctrl.rout;
    assign bus.BAout                = ctrl.ba_out;
    assign bus.CON_in               = ctrl.con_in;
    assign bus.Link_in              = ctrl.link_in;
    assign bus.alu_instruction_bits = ctrl.alu;
    assign bus.run                  = ctrl.run;
endmodule

// File: tb/tb_control_sequencer.sv
// Randomized bench for control_sequencer: two lanes (MEM_WAIT 0 and 2) checked every cycle
// against a per-instruction step table built from the opcode.
module tb_control_sequencer;

    typedef struct packed {
        logic pc_in, ir_in, y_in, z_in, hi_in, lo_in, mar_in, mdr_in, outport_in, inc_pc;
        logic pc_out, zhigh_out, zlow_out, hi_out, lo_out, mdr_out, inport_out, c_out;
        logic read, write, gra, grb, grc, rin, rout, ba_out, con_in, link_in;
        logic [4:0] alu;
        logic run;
    } cw_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    bit   done = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    task automatic chk_cw(input string name, input cw_t got, input cw_t exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s t=%0t got=%h expected=%h", name, $time, got, exp);
        end
    endtask

    task automatic chk_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", name, got, exp);
        end
    endtask

    function automatic cw_t base();
        cw_t w;
        w = '0;
        w.run = 1'b1;
        return w;
    endfunction

    // Expected control words for one whole instruction, one entry per clock.
    // con_at marks the branch step whose PC_in must follow CON_out.
    function automatic void build(input logic [31:0] ir, input int mw,
                                  output cw_t q[$], output int con_at);
        cw_t w;
        int  op;
        op = int'(ir[31:27]);
        q = {};
        con_at = -1;
        w = base(); w.pc_out = 1; w.mar_in = 1; w.inc_pc = 1; w.z_in = 1; q.push_back(w);
        for (int i = 0; i <= mw; i++) begin
            w = base(); w.read = 1; w.mdr_in = 1; w.zlow_out = (i == 0); w.pc_in = (i == 0);
            q.push_back(w);
        end
        w = base(); w.mdr_out = 1; w.ir_in = 1; q.push_back(w);
        if (op >= 3 && op <= 14) begin
            w = base(); w.grb = 1; w.rout = 1; w.y_in = 1; q.push_back(w);
            w = base(); w.z_in = 1;
            if (op <= 11) begin w.grc = 1; w.rout = 1; w.alu = 5'(op); end
            else begin w.c_out = 1; w.alu = (op == 12) ? 5'd3 : (op == 13) ? 5'd5 : 5'd6; end
            q.push_back(w);
            w = base(); w.zlow_out = 1; w.gra = 1; w.rin = 1; q.push_back(w);
        end else if (op == 17 || op == 18) begin
            w = base(); w.grb = 1; w.rout = 1; w.z_in = 1; w.alu = 5'(op); q.push_back(w);
            w = base(); w.zlow_out = 1; w.gra = 1; w.rin = 1; q.push_back(w);
`ifdef CU_MULDIV_EN
        end else if (op == 15 || op == 16) begin
            w = base(); w.gra = 1; w.rout = 1; w.y_in = 1; q.push_back(w);
            w = base(); w.grb = 1; w.rout = 1; w.z_in = 1; w.alu = 5'(op); q.push_back(w);
            w = base(); w.zlow_out = 1; w.lo_in = 1; q.push_back(w);
            w = base(); w.zhigh_out = 1; w.hi_in = 1; q.push_back(w);
`endif
        end else if (op <= 2) begin
            w = base(); w.grb = 1; w.ba_out = 1; w.y_in = 1; q.push_back(w);
            w = base(); w.c_out = 1; w.z_in = 1; w.alu = 5'd3; q.push_back(w);
            w = base(); w.zlow_out = 1;
            if (op == 1) begin w.gra = 1; w.rin = 1; end else w.mar_in = 1;
            q.push_back(w);
            if (op == 0) begin
                for (int i = 0; i <= mw; i++) begin
                    w = base(); w.read = 1; w.mdr_in = 1; q.push_back(w);
                end
                w = base(); w.mdr_out = 1; w.gra = 1; w.rin = 1; q.push_back(w);
            end else if (op == 2) begin
                w = base(); w.gra = 1; w.rout = 1; w.mdr_in = 1; q.push_back(w);
                for (int i = 0; i <= mw; i++) begin
                    w = base(); w.write = 1; q.push_back(w);
                end
            end
        end else if (op == 19) begin
            w = base(); w.gra = 1; w.rout = 1; w.con_in = 1; q.push_back(w);
            w = base(); w.pc_out = 1; w.y_in = 1; q.push_back(w);
            w = base(); w.c_out = 1; w.z_in = 1; w.alu = 5'd3; q.push_back(w);
            con_at = q.size();
            w = base(); w.zlow_out = 1; q.push_back(w);
        end else if (op == 20) begin
            w = base(); w.gra = 1; w.rout = 1; w.pc_in = 1; q.push_back(w);
        end else if (op == 21) begin
            w = base(); w.pc_out = 1; w.link_in = 1; q.push_back(w);
            w = base(); w.gra = 1; w.rout = 1; w.pc_in = 1; q.push_back(w);
        end else if (op == 22) begin
            w = base(); w.inport_out = 1; w.gra = 1; w.rin = 1; q.push_back(w);
        end else if (op == 23) begin
            w = base(); w.gra = 1; w.rout = 1; w.outport_in = 1; q.push_back(w);
        end else if (op == 24) begin
            w = base(); w.hi_out = 1; w.gra = 1; w.rin = 1; q.push_back(w);
        end else if (op == 25) begin
            w = base(); w.lo_out = 1; w.gra = 1; w.rin = 1; q.push_back(w);
        end else if (op == 27) begin
            w = '0; q.push_back(w);
        end
    endfunction

    function automatic logic [31:0] pick();
        int unsigned op;
        op = $urandom_range(0, 31);
        if (op == 27 && $urandom_range(0, 3) != 0) op = 3;
        return {5'(op), 27'($urandom)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int MW = 2 * g;
        control_sequencer_if bus_if ();
        control_sequencer #(.MEM_WAIT(MW)) dut (
            .clk (clk),
            .clr (clr),
            .bus (bus_if)
        );
        cw_t act_w;
        assign act_w = {bus_if.PC_in, bus_if.IR_in, bus_if.Y_in, bus_if.Z_in, bus_if.HI_in,
                        bus_if.LO_in, bus_if.MAR_in, bus_if.MDR_in, bus_if.OutPort_in,
                        bus_if.IncPC, bus_if.PC_out, bus_if.Zhigh_out, bus_if.Zlow_out,
                        bus_if.HI_out, bus_if.LO_out, bus_if.MDR_out, bus_if.InPort_out,
                        bus_if.C_out, bus_if.Read, bus_if.Write, bus_if.Gra, bus_if.Grb,
                        bus_if.Grc, bus_if.Rin, bus_if.Rout, bus_if.BAout, bus_if.CON_in,
                        bus_if.Link_in, bus_if.alu_instruction_bits, bus_if.run};

        cw_t         exp_q[$];
        cw_t         e;
        logic [31:0] ir;
        int          con_at;
        int          pos;
        bit          con;
        bit          halted;

        initial begin
            bus_if.IR_Data = '0;
            bus_if.CON_out = 1'b0;
            con = 1'b0;
            halted = 1'b0;
            pos = 0;
            con_at = -1;
            ir = '0;
            exp_q = {};
            while (!done) begin
                @(negedge clk);
                if (clr) begin
                    e = '0;
                    exp_q = {};
                    halted = 1'b0;
                end else if (halted) begin
                    e = '0;
                end else begin
                    if (exp_q.size() == 0) begin
                        ir = pick();
                        build(ir, MW, exp_q, con_at);
                        pos = 0;
                    end
                    e = exp_q.pop_front();
                    if (pos == con_at) e.pc_in = con;
                    pos++;
                    if (exp_q.size() == 0 && ir[31:27] == 5'd27) halted = 1'b1;
                end
                chk_cw($sformatf("lane%0d ctrl ir=%h", g, ir), act_w, e);
                @(posedge clk);
                #1;
                // Stand-in for the datapath: IR and CON flip-flop capture on this edge.
                if (e.ir_in) bus_if.IR_Data = ir;
                if (e.con_in) begin
                    con = 1'($urandom_range(0, 1));
                    bus_if.CON_out = con;
                end
            end
        end
    end

    initial begin
        cw_t q[$];
        cw_t t0_lit;
        int  ca;
        int  reads;
        t0_lit = '0;
        t0_lit.pc_out = 1; t0_lit.mar_in = 1; t0_lit.inc_pc = 1; t0_lit.z_in = 1; t0_lit.run = 1;

        // Model pinned against hand-counted lengths and fields.
        build(32'h1A920000, 0, q, ca);
        chk_int("add length", q.size(), 6);
        chk_int("add T4 alu", int'(q[4].alu), 3);
        chk_cw("add T0 word", q[0], t0_lit);
        build(32'h00800054, 2, q, ca);
        chk_int("ld mw2 length", q.size(), 12);
        reads = 0;
        foreach (q[i]) if (q[i].read) reads++;
        chk_int("ld mw2 read cycles", reads, 6);
        build(32'h9B000019, 0, q, ca);
        chk_int("br length", q.size(), 7);
        chk_int("br con step", ca, 6);
        build(32'hD0000000, 0, q, ca);
        chk_int("nop length", q.size(), 3);
        build(32'hA8000000, 0, q, ca);
        chk_int("jal length", q.size(), 5);
        build(32'hD8000000, 0, q, ca);
        chk_int("halt T3 run", int'(q[3].run), 0);
        build(32'h81A00000, 0, q, ca);
`ifdef CU_MULDIV_EN
        chk_int("mul length", q.size(), 7);
`else
        chk_int("mul length", q.size(), 3);
`endif

        @(negedge clk);
        chk_cw("reset outputs lane0", lane[0].act_w, '0);
        chk_cw("reset outputs lane1", lane[1].act_w, '0);
        @(posedge clk);
        #1 clr = 1'b0;
        @(negedge clk);
        chk_cw("first fetch lane0", lane[0].act_w, t0_lit);
        chk_cw("first fetch lane1", lane[1].act_w, t0_lit);

        for (int r = 0; r < 30; r++) begin
            repeat ($urandom_range(30, 200)) @(posedge clk);
            #1 clr = 1'b1;
            repeat ($urandom_range(1, 2)) @(posedge clk);
            #1 clr = 1'b0;
        end
        repeat (50) @(posedge clk);
        done = 1'b1;
        repeat (3) @(posedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
